rsa_mm_master: RTL
==================

RSA_MM_MASTER -- requirements
Module: rsa_mm_master

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 8: idle bus cycles between the last write and the first read (0 allowed).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_op  input  2  01 key, 10 encrypt, 11 decrypt, 00 invalid.
REQ-007 SHALL have port cmd_data  input  384  operand; key uses [127:0], encrypt [159:0], decrypt [383:0].
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  result consumed when high with res_valid.
REQ-010 SHALL have port res_data  output  128  result, word i = read of address i.
REQ-011 SHALL have ports m_chipselect out 1, m_write out 1, m_address out 3, m_writedata out 32, m_readdata in 32: Avalon-MM master to the RSA register slave; no waitrequest.

Function
REQ-012 SHALL implement states IDLE, WRITE, WAIT, READ, DONE.
REQ-013 SHALL drive cmd_ready = (state==IDLE) and not reset; accept captures cmd_op/cmd_data and moves to WRITE.
REQ-014 SHALL issue one write per cycle (m_chipselect=m_write=1), first write in the cycle after acceptance.
REQ-015 SHALL, for key: addr0=0x1, then addr1..4 = cmd_data words 0..3 (5 writes).
REQ-016 SHALL, for encrypt: addr0=0x2, then addr1..5 = words 0..4 (6 writes).
REQ-017 SHALL, for decrypt, for page p=0..2: addr0=0x3|(p<<2), then addr1..4 = words 4p..4p+3 (15 writes).
REQ-018 SHALL hold m_chipselect, m_write low and m_address, m_writedata at 0 outside write/read cycles.
REQ-019 SHALL spend exactly WAIT_CYCLES cycles in WAIT; WAIT_CYCLES=0 goes WRITE->READ directly.
REQ-020 SHALL issue reads (m_chipselect=1, m_write=0) to addr0..3 on 4 consecutive cycles; read latency 1: m_readdata for address i is captured on the edge ending the cycle after its request.
REQ-021 SHALL assert res_valid exactly Nw+WAIT_CYCLES+6 cycles after the accept edge (Nw = write count); res_data stable while res_valid.
REQ-022 SHALL hold DONE until res_valid&&res_ready, then go to IDLE; no same-cycle new accept.
REQ-023 SHALL accept cmd_op=00 with no bus traffic, entering DONE next cycle with res_data=0.

Reset
REQ-024 SHALL, on reset (including mid-operation), enter IDLE next edge: res_valid=0, res_data=0, all m_* outputs 0, captured command cleared.
REQ-025 SHALL hold cmd_ready low during any cycle reset is high.

Configuration
REQ-026 SHALL, with RSA_MM_PERF_EN defined, add output perf_cycles (32): cycles from accept to res_valid, updated when res_valid rises, reset to 0, saturating at 0xFFFFFFFF.
REQ-027 SHALL, without RSA_MM_PERF_EN, have no perf_cycles port or counter.

Structure
REQ-028 SHALL place in package rsa_mm_pkg: op enum, state enum, instruction codes (0x1, 0x2, 0x3), page shift (2), address constants, write counts (5/6/15).
REQ-029 SHALL use sub-module rsa_mm_wr_seq: combinational map (op, step index) -> (m_address, m_writedata, last-write flag).

Verification
REQ-030 SHALL check key, data words 0x11,0x22,0x33,0x44 -> writes (0,1)(1,0x11)(2,0x22)(3,0x33)(4,0x44), reads 0..3, res_valid at cycle 19.
REQ-031 SHALL check encrypt with 5 words -> addr0=0x2 then addr1..5 in order, res_valid at cycle 20, res_data equals the four read words.
REQ-032 SHALL check decrypt -> instruction words 0x3, 0x7, 0xB at addr0 each followed by four words, 15 writes total, res_valid at cycle 29.
REQ-033 SHALL check res_ready held low 10 cycles -> res_valid and res_data stable, cmd_ready low until the cycle after the handshake.
REQ-034 SHALL check reset asserted during the 3rd write -> bus idle and cmd_ready high the cycle after reset deasserts; the next key command completes normally.
REQ-035 SHALL check cmd_op=00 -> no m_chipselect pulse, res_valid the second cycle after accept, res_data=0.

Source files
------------

// File: rtl/rsa_mm_pkg.sv
// rsa_mm_pkg -- shared definitions for the RSA Avalon-MM command master.
//
// Contents: command op encoding, master FSM states, instruction codes written
// to the slave control register, decrypt page shift, slave address constants
// and per-op write counts.
package rsa_mm_pkg;

    typedef enum logic [1:0] {
        OP_INV = 2'b00,
        OP_KEY = 2'b01,
        OP_ENC = 2'b10,
        OP_DEC = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT,
        READ,
        DONE
    } state_e;

    // Instruction words written to the control register at address 0.
    localparam logic [31:0] INSTR_KEY = 32'h1;
    localparam logic [31:0] INSTR_ENC = 32'h2;
    localparam logic [31:0] INSTR_DEC = 32'h3;

    // Decrypt page number is placed above the two instruction bits.
    localparam int PAGE_SHIFT = 2;

    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam int         N_RD      = 4;   // result words read back (addr 0..3)

    // Total bus writes per operation, including instruction words.
    localparam int NW_KEY = 5;
    localparam int NW_ENC = 6;
    localparam int NW_DEC = 15;

    localparam int STEP_W = 4;              // wide enough for NW_DEC-1

endpackage

// File: rtl/rsa_mm_wr_seq.sv
// rsa_mm_wr_seq -- combinational write-sequence map.
//
// For the captured op and the current write step, produce the slave address,
// write data and whether this step is the final write of the command.
//
// Ports:
//   op        in   captured command op
//   step      in   write index, 0 = first write of the command
//   data      in   captured 384-bit operand (word i = data[32i+31:32i])
//   address   out  slave register address for this write
//   writedata out  value written
//   last      out  high on the final write (always high for an invalid op)
module rsa_mm_wr_seq
    import rsa_mm_pkg::*;
(
    input  op_e               op,
    input  logic [STEP_W-1:0] step,
    input  logic [383:0]      data,
    output logic [2:0]        address,
    output logic [31:0]       writedata,
    output logic              last
);

    logic [11:0][31:0] words;
    logic [1:0]        page;   // decrypt page, 0 for key/encrypt
    logic [3:0]        sub;    // position within the page, 0 = instruction word
    logic [3:0]        widx;   // operand word index for data writes
    logic [31:0]       instr;

    assign words = data;

    always_comb begin
        // NOTE: every output and temporary gets a default before the case so no
        // path through the block leaves a value held, which would infer a latch.
        address   = '0;
        writedata = '0;
        last      = 1'b1;
        page      = '0;
        sub       = '0;
        widx      = '0;
        instr     = '0;

        unique case (op)
            OP_KEY: begin
                sub   = step;
                instr = INSTR_KEY;
                last  = (step == STEP_W'(NW_KEY - 1));
            end
            OP_ENC: begin
                sub   = step;
                instr = INSTR_ENC;
                last  = (step == STEP_W'(NW_ENC - 1));
            end
            OP_DEC: begin
                // Three pages of five writes: instruction word then four operands.
                if (step < 4'd5) begin
                    page = 2'd0;
                    sub  = step;
                end else if (step < 4'd10) begin
                    page = 2'd1;
                    sub  = step - 4'd5;
                end else begin
                    page = 2'd2;
                    sub  = step - 4'd10;
                end
                instr = INSTR_DEC | (32'(page) << PAGE_SHIFT);
                last  = (step == STEP_W'(NW_DEC - 1));
            end
            default: ;
        endcase

        if (op != OP_INV) begin
            if (sub == 4'd0) begin
                address   = ADDR_CTRL;
                writedata = instr;
            end else begin
                address   = sub[2:0];
                widx      = {page, 2'b00} + sub - 4'd1;
                writedata = words[widx];
            end
        end
    end

endmodule

// File: rtl/rsa_mm_master.sv
// rsa_mm_master -- command-driven Avalon-MM master for an RSA register slave.
//
// A command (key load, encrypt, decrypt) is accepted on the cmd_* handshake,
// written to the slave one word per cycle, followed by WAIT_CYCLES idle bus
// cycles, then four result words are read (read latency 1) and presented on
// the res_* handshake. An invalid op produces a zero result with no bus
// traffic.
//
// Parameters:
//   WAIT_CYCLES   idle cycles between last write and first read (0 allowed)
// Build option:
//   RSA_MM_PERF_EN  adds perf_cycles: accept-to-result cycle count
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_data operand
//   res_valid/res_ready         result handshake; res_data four read words
//   m_chipselect, m_write,
//   m_address, m_writedata      Avalon-MM master request (no waitrequest)
//   m_readdata                  read data, valid the cycle after the request
//   perf_cycles                 (RSA_MM_PERF_EN only) last command latency
module rsa_mm_master
    import rsa_mm_pkg::*;
#(
    parameter int WAIT_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [383:0] cmd_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         m_chipselect,
    output logic         m_write,
    output logic [2:0]   m_address,
    output logic [31:0]  m_writedata,
`ifdef RSA_MM_PERF_EN
    output logic [31:0]  perf_cycles,
`endif
    input  logic [31:0]  m_readdata
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e            state, state_next;
    op_e               op_q;
    logic [383:0]      data_q;
    logic [STEP_W-1:0] step;
    logic [WCW-1:0]    wait_cnt;
    logic [2:0]        rd_idx;      // 0..3 issue reads, 4 drains the last read
    logic [2:0]        seq_addr;
    logic [31:0]       seq_wdata;
    logic              seq_last;
    logic              accept;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign res_valid = (state == DONE);

    rsa_mm_wr_seq u_wr_seq (
        .op        (op_q),
        .step      (step),
        .data      (data_q),
        .address   (seq_addr),
        .writedata (seq_wdata),
        .last      (seq_last)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept) state_next = WRITE;
            WRITE: begin
                if (seq_last) begin
                    if (op_q == OP_INV)        state_next = DONE;
                    else if (WAIT_CYCLES == 0) state_next = READ;
                    else                       state_next = WAIT;
                end
            end
            WAIT:  if (32'(wait_cnt) == 32'(WAIT_CYCLES - 1)) state_next = READ;
            READ:  if (rd_idx == 3'(N_RD)) state_next = DONE;
            DONE:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are decoded from registered state only.
    always_comb begin
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        unique case (state)
            WRITE: begin
                if (op_q != OP_INV) begin
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_address    = seq_addr;
                    m_writedata  = seq_wdata;
                end
            end
            READ: begin
                if (rd_idx < 3'(N_RD)) begin
                    m_chipselect = 1'b1;
                    m_address    = rd_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand register is cleared too, so nothing from an
            // aborted command can leak into the next one.
            state    <= IDLE;
            op_q     <= OP_INV;
            data_q   <= '0;
            step     <= '0;
            wait_cnt <= '0;
            rd_idx   <= '0;
            res_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_e'(cmd_op);
                        data_q   <= cmd_data;
                        step     <= '0;
                        res_data <= '0;
                    end
                end
                WRITE: begin
                    step     <= step + 1'b1;
                    wait_cnt <= '0;
                    rd_idx   <= '0;
                end
                WAIT: wait_cnt <= wait_cnt + 1'b1;
                READ: begin
                    rd_idx <= rd_idx + 1'b1;
                    // Data for the read issued last cycle is on the bus now.
                    unique case (rd_idx)
                        3'd1: res_data[31:0]   <= m_readdata;
                        3'd2: res_data[63:32]  <= m_readdata;
                        3'd3: res_data[95:64]  <= m_readdata;
                        3'd4: res_data[127:96] <= m_readdata;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef RSA_MM_PERF_EN
    logic [31:0] perf_cnt;

    // perf_cnt holds the 1-based cycle number since accept; the value latched
    // on entry to DONE is the cycle in which res_valid first shows.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) begin
                perf_cnt <= 32'd1;
            end else if ((state == WRITE || state == WAIT || state == READ)
                         && perf_cnt != '1) begin
                perf_cnt <= perf_cnt + 1'b1;
            end
            if (state != DONE && state_next == DONE) begin
                perf_cycles <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 1'b1;
            end
        end
    end
`else
    // No latency counter in this build.
`endif

endmodule
